// File: rtl/bounce_generator_if.sv
// Bounce generator bus: press request in, bouncy button and status out.
// master drives start/hold_counts; slave returns button/busy/done.
interface bounce_generator_if;
  logic        start;
  logic [15:0] hold_counts;
  logic        button;
  logic        busy;
  logic        done;

  modport master (
    output start,
    output hold_counts,
    input  button,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  hold_counts,
    output button,
    output busy,
    output done
  );
endinterface

// File: rtl/bounce_generator.sv
// Synthetic mechanical-button model: LFSR-timed contact bounce on press
// and release, a clean hold in between, busy for the whole press, done
// pulse at the end.
// Ports: clk, reset (async, active-high); bus.slave carries start,
// hold_counts (in) and button, busy, done (registered out).
module bounce_generator #(
  parameter int unsigned BOUNCE_COUNTS = 500,
  parameter int unsigned GAP_BITS      = 4,
  parameter logic [15:0] SEED          = 16'hACE1
) (
  input  logic clk,
  input  logic reset,
  bounce_generator_if.slave bus
);

  localparam logic [15:0] SEED_EFF =
    (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam logic [15:0] BC_M1 =
    16'(BOUNCE_COUNTS - 1);
  localparam int GW = GAP_BITS + 1;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_BOUNCE,
    HOLD,
    RELEASE_BOUNCE
  } state_e;

  state_e        state_q, state_d;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [15:0]   hold_q, hold_d;
  logic          button_q, button_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [GW-1:0] gap_load;

  // Galois LFSR; a nonzero state never maps to zero.
  assign lfsr_d = {1'b0, lfsr_q[15:1]}
                ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);

  // Gap of 1..2^GAP_BITS cycles.
  assign gap_load = GW'(lfsr_q[GAP_BITS-1:0]) + GW'(1);

  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    button_d = button_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        button_d = 1'b0;
        busy_d   = 1'b0;
        if (bus.start) begin
          state_d  = PRESS_BOUNCE;
          button_d = 1'b1;
          busy_d   = 1'b1;
          hold_d   = (bus.hold_counts == 16'd0)
                   ? 16'd1 : bus.hold_counts;
          cnt_d    = BC_M1;
          gap_d    = gap_load;
        end
      end
      PRESS_BOUNCE, RELEASE_BOUNCE: begin
        if (cnt_q == 16'd0) begin
          // Forced end level overrides any toggle due now.
          if (state_q == PRESS_BOUNCE) begin
            state_d  = HOLD;
            button_d = 1'b1;
            cnt_d    = hold_q - 16'd1;
            gap_d    = '0;
          end else begin
            state_d  = IDLE;
            button_d = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
            cnt_d    = 16'd0;
            gap_d    = '0;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
          if (gap_q == GW'(1)) begin
            button_d = ~button_q;
            gap_d    = gap_load;
          end else begin
            gap_d = gap_q - GW'(1);
          end
        end
      end
      HOLD: begin
        button_d = 1'b1;
        if (cnt_q == 16'd0) begin
          state_d  = RELEASE_BOUNCE;
          button_d = 1'b0;
          cnt_d    = BC_M1;
          gap_d    = gap_load;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      lfsr_q   <= SEED_EFF;
      gap_q    <= '0;
      cnt_q    <= 16'd0;
      hold_q   <= 16'd0;
      button_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      gap_q    <= gap_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      button_q <= button_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.button = button_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_bounce_generator.sv
// Directed bench for bounce_generator: default and short-bounce
// instances, reset, hold timing, abort/rerun, start handling.
module tb_bounce_generator;

  logic clk;
  logic reset;
  int   vecs;
  int   errs;

  bounce_generator_if bif ();
  bounce_generator_if sif ();

  bounce_generator dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif.slave)
  );

  bounce_generator #(
    .BOUNCE_COUNTS (8),
    .GAP_BITS      (1)
  ) dut_s (
    .clk   (clk),
    .reset (reset),
    .bus   (sif.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  localparam int N = 6002;

  logic wb [0:N];
  logic wy [0:N];
  logic wd [0:N];
  logic wa [0:N];
  logic wc [0:N];
  logic sb [0:63];
  logic sy [0:63];
  logic sd [0:63];

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  // Start a press on the default instance and record n samples;
  // hold_counts is scrambled after acceptance.
  task automatic capture_default(input int n, input logic [15:0] hc);
    bif.start = 1'b1;
    bif.hold_counts = hc;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bif.start = 1'b0;
        bif.hold_counts = 16'd3;
      end
      wb[k] = bif.button;
      wy[k] = bif.busy;
      wd[k] = bif.done;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    vecs++;
    if (bif.button !== 1'b0) begin
      errs++;
      $display("FAIL reset_button: got %b want 0", bif.button);
    end
    vecs++;
    if (bif.busy !== 1'b0) begin
      errs++;
      $display("FAIL reset_busy: got %b want 0", bif.busy);
    end
    vecs++;
    if (bif.done !== 1'b0) begin
      errs++;
      $display("FAIL reset_done: got %b want 0", bif.done);
    end
    vecs++;
    if (sif.busy !== 1'b0 || sif.button !== 1'b0) begin
      errs++;
      $display("FAIL reset_small: got busy=%b button=%b want 0/0",
               sif.busy, sif.button);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_default_press();
    int bc, dc, di, hc, tg;
    do_reset();
    capture_default(N, 16'd5000);
    bc = 0; dc = 0; di = 0; hc = 0; tg = 0;
    for (int k = 1; k <= N; k++) begin
      if (wy[k] === 1'b1) bc++;
      if (wd[k] === 1'b1) begin
        dc++;
        di = k;
      end
      wa[k] = wb[k];
    end
    for (int k = 501; k <= 5500; k++)
      if (wb[k] === 1'b1) hc++;
    for (int k = 2; k <= 500; k++)
      if (wb[k] !== wb[k-1]) tg++;
    vecs++;
    if (bc != 6000) begin
      errs++;
      $display("FAIL busy_len: got %0d want 6000", bc);
    end
    vecs++;
    if (dc != 1 || di != 6001) begin
      errs++;
      $display("FAIL done_pulse: got count %0d at %0d want 1 at 6001",
               dc, di);
    end
    vecs++;
    if (hc != 5000) begin
      errs++;
      $display("FAIL hold_high: got %0d want 5000", hc);
    end
    vecs++;
    if (wb[1] !== 1'b1) begin
      errs++;
      $display("FAIL press_first: got %b want 1", wb[1]);
    end
    vecs++;
    if (wb[5501] !== 1'b0) begin
      errs++;
      $display("FAIL release_first: got %b want 0", wb[5501]);
    end
    vecs++;
    if (wb[6001] !== 1'b0 || wb[6002] !== 1'b0) begin
      errs++;
      $display("FAIL button_after: got %b%b want 00",
               wb[6001], wb[6002]);
    end
    vecs++;
    if (tg == 0) begin
      errs++;
      $display("FAIL press_bounce: got %0d toggles want >0", tg);
    end
  endtask

  task automatic test_abort_rerun();
    int dseen, mm, dc;
    do_reset();
    capture_default(600, 16'd5000);
    for (int k = 1; k <= 600; k++) wc[k] = wb[k];
    #1;
    reset = 1'b1;
    #1;
    vecs++;
    if (bif.button !== 1'b0 || bif.busy !== 1'b0) begin
      errs++;
      $display("FAIL abort_async: got button=%b busy=%b want 0/0",
               bif.button, bif.busy);
    end
    dseen = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (bif.done !== 1'b0) dseen++;
    end
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (bif.done !== 1'b0 || bif.busy !== 1'b0) dseen++;
    end
    vecs++;
    if (dseen != 0) begin
      errs++;
      $display("FAIL abort_no_done: got %0d bad samples want 0", dseen);
    end
    mm = 0;
    for (int k = 1; k <= 600; k++)
      if (wc[k] !== wa[k]) mm++;
    vecs++;
    if (mm != 0) begin
      errs++;
      $display("FAIL abort_prefix: got %0d diffs want 0", mm);
    end
    capture_default(N, 16'd5000);
    mm = 0;
    dc = 0;
    for (int k = 1; k <= N; k++) begin
      if (wb[k] !== wa[k]) mm++;
      if (wd[k] === 1'b1) dc++;
    end
    vecs++;
    if (mm != 0) begin
      errs++;
      $display("FAIL rerun_wave: got %0d diffs want 0", mm);
    end
    vecs++;
    if (dc != 1) begin
      errs++;
      $display("FAIL rerun_done: got %0d want 1", dc);
    end
  endtask

  task automatic test_short_hold();
    int bc, dc, di, viol, last;
    sif.hold_counts = 16'd0;
    sif.start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) sif.start = 1'b0;
      sb[k] = sif.button;
      sy[k] = sif.busy;
      sd[k] = sif.done;
    end
    bc = 0; dc = 0; di = 0; viol = 0;
    for (int k = 1; k <= 20; k++) begin
      if (sy[k] === 1'b1) bc++;
      if (sd[k] === 1'b1) begin
        dc++;
        di = k;
      end
    end
    last = 1;
    for (int k = 2; k <= 8; k++)
      if (sb[k] !== sb[k-1]) begin
        if (k - last > 2) viol++;
        last = k;
      end
    if (9 - last > 2) viol++;
    last = 10;
    for (int k = 11; k <= 17; k++)
      if (sb[k] !== sb[k-1]) begin
        if (k - last > 2) viol++;
        last = k;
      end
    if (18 - last > 2) viol++;
    vecs++;
    if (bc != 17) begin
      errs++;
      $display("FAIL short_busy: got %0d want 17", bc);
    end
    vecs++;
    if (dc != 1 || di != 18) begin
      errs++;
      $display("FAIL short_done: got count %0d at %0d want 1 at 18",
               dc, di);
    end
    vecs++;
    if (sb[9] !== 1'b1 || sb[10] !== 1'b0) begin
      errs++;
      $display("FAIL short_hold: got %b%b want 10", sb[9], sb[10]);
    end
    vecs++;
    if (sb[1] !== 1'b1 || sb[18] !== 1'b0) begin
      errs++;
      $display("FAIL short_ends: got %b%b want 10", sb[1], sb[18]);
    end
    vecs++;
    if (viol != 0) begin
      errs++;
      $display("FAIL short_gaps: got %0d violations want 0", viol);
    end
  endtask

  task automatic test_ignore_start();
    int bc, dc;
    sif.start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      sif.start = (k <= 16);
      sb[k] = sif.button;
      sy[k] = sif.busy;
      sd[k] = sif.done;
    end
    bc = 0; dc = 0;
    for (int k = 1; k <= 20; k++) begin
      if (sy[k] === 1'b1) bc++;
      if (sd[k] === 1'b1) dc++;
    end
    vecs++;
    if (bc != 17) begin
      errs++;
      $display("FAIL ignore_busy: got %0d want 17", bc);
    end
    vecs++;
    if (dc != 1 || sd[18] !== 1'b1) begin
      errs++;
      $display("FAIL ignore_done: got count %0d d18=%b want 1/1",
               dc, sd[18]);
    end
  endtask

  task automatic test_back_to_back();
    int b2, dc;
    sif.start = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      sif.start = (k == 18);
      sb[k] = sif.button;
      sy[k] = sif.busy;
      sd[k] = sif.done;
    end
    b2 = 0; dc = 0;
    for (int k = 19; k <= 40; k++)
      if (sy[k] === 1'b1) b2++;
    for (int k = 1; k <= 40; k++)
      if (sd[k] === 1'b1) dc++;
    vecs++;
    if (sd[18] !== 1'b1 || sy[19] !== 1'b1 || sb[19] !== 1'b1) begin
      errs++;
      $display("FAIL b2b_restart: got done=%b busy=%b btn=%b want 111",
               sd[18], sy[19], sb[19]);
    end
    vecs++;
    if (b2 != 17 || sd[36] !== 1'b1) begin
      errs++;
      $display("FAIL b2b_second: got busy %0d d36=%b want 17/1",
               b2, sd[36]);
    end
    vecs++;
    if (dc != 2) begin
      errs++;
      $display("FAIL b2b_dones: got %0d want 2", dc);
    end
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    reset = 1'b0;
    bif.start = 1'b0;
    bif.hold_counts = 16'd0;
    sif.start = 1'b0;
    sif.hold_counts = 16'd0;
    test_reset();
    test_default_press();
    test_abort_rerun();
    test_short_hold();
    test_ignore_start();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
